// File: rtl/gsim_sched.sv
// gsim_sched: control sequencer for the Gauss-Seidel solver (b load, row issue, write-back, drain, readout).
// Latency: b_we/b_waddr are combinational from in_en; every other output is decoded from registered state,
//          and {wb_en, wb_row} is {issue_valid, issue_row} delayed exactly PE_LAT cycles.
// Backpressure: none. in_en is accepted only in IDLE/LOAD and ignored otherwise; downstream always keeps up.
//
// Ports:
//   clk, reset            single clock, asynchronous active-high reset
//   in_en                 a b value is present this cycle
//   b_we, b_waddr         b storage write strobe / address
//   issue_valid, issue_row, nbr_mask   PE operand strobe, row index, neighbour enables
//   wb_en, wb_row         PE result write-back strobe / x address
//   out_valid, out_idx    result readout strobe / x address
//   busy, done            not idle / one-cycle end-of-solve pulse
module gsim_sched #(
    parameter int N            = 16,
    parameter int NR_ITERATION = 100,
    parameter int PE_LAT       = 3,
    localparam int RW          = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_en,
    output logic          b_we,
    output logic [RW-1:0] b_waddr,
    output logic          issue_valid,
    output logic [RW-1:0] issue_row,
    output logic [5:0]    nbr_mask,
    output logic          wb_en,
    output logic [RW-1:0] wb_row,
    output logic          out_valid,
    output logic [RW-1:0] out_idx,
    output logic          busy,
    output logic          done
);

    localparam int IW = (NR_ITERATION > 1) ? $clog2(NR_ITERATION) : 1;
    localparam int DW = (PE_LAT > 1) ? $clog2(PE_LAT) : 1;

    localparam logic [RW-1:0] ROW_LAST  = RW'(N - 1);
    localparam logic [IW-1:0] ITER_LAST = IW'(NR_ITERATION - 1);
    localparam logic [DW-1:0] DRN_LAST  = DW'(PE_LAT - 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_CALC,
        S_DRAIN,
        S_OUT
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic [RW-1:0]   load_cnt;
    logic [RW-1:0]   row;
    logic [DW-1:0]   drn_cnt;
    logic [IW-1:0]   iter;
    logic [RW-1:0]   out_cnt;
    logic [5:0]      mask_row;

    // {valid, row} delay line feeding the write-back port.
    logic [RW:0]     wb_pipe [PE_LAT];

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and decoded outputs.
    always_comb begin
        state_nxt   = state;
        b_we        = 1'b0;
        b_waddr     = load_cnt;
        issue_valid = 1'b0;
        issue_row   = '0;
        nbr_mask    = '0;
        out_valid   = 1'b0;
        out_idx     = '0;
        done        = 1'b0;
        busy        = (state != S_IDLE);

        case (state)
            S_IDLE, S_LOAD: begin
                b_we = in_en;
                if (in_en) begin
                    state_nxt = (load_cnt == ROW_LAST) ? S_CALC : S_LOAD;
                end
            end
            S_CALC: begin
                issue_valid = 1'b1;
                issue_row   = row;
                nbr_mask    = mask_row;
                if (row == ROW_LAST) begin
                    state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (drn_cnt == DRN_LAST) begin
                    state_nxt = (iter == ITER_LAST) ? S_OUT : S_CALC;
                end
            end
            S_OUT: begin
                out_valid = 1'b1;
                out_idx   = out_cnt;
                if (out_cnt == ROW_LAST) begin
                    done      = 1'b1;
                    state_nxt = S_IDLE;
                end
            end
            default: state_nxt = S_IDLE;
        endcase
    end

    // Neighbour enables: bit 2k covers x[i-(k+1)], bit 2k+1 covers x[i+(k+1)];
    // each is set only when that index falls inside 0..N-1.
    always_comb begin
        mask_row = '0;
        for (int k = 0; k < 3; k++) begin
            mask_row[2*k]   = (int'(row) >= k + 1);
            mask_row[2*k+1] = (int'(row) + k + 1 <= N - 1);
        end
    end

    // Counters. Each wraps to 0 on its last value, so it is already cleared
    // when its state is re-entered (row for the next iteration, load_cnt for
    // the next solve, and so on).
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            load_cnt <= '0;
            row      <= '0;
            drn_cnt  <= '0;
            iter     <= '0;
            out_cnt  <= '0;
        end else begin
            case (state)
                S_IDLE, S_LOAD: begin
                    if (in_en) begin
                        load_cnt <= (load_cnt == ROW_LAST) ? '0 : load_cnt + RW'(1);
                    end
                end
                S_CALC: begin
                    row <= (row == ROW_LAST) ? '0 : row + RW'(1);
                end
                S_DRAIN: begin
                    if (drn_cnt == DRN_LAST) begin
                        drn_cnt <= '0;
                        iter    <= (iter == ITER_LAST) ? '0 : iter + IW'(1);
                    end else begin
                        drn_cnt <= drn_cnt + DW'(1);
                    end
                end
                S_OUT: begin
                    out_cnt <= (out_cnt == ROW_LAST) ? '0 : out_cnt + RW'(1);
                end
                default: ;
            endcase
        end
    end

    // Write-back tracking runs regardless of state; reset flushes rows in flight.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < PE_LAT; i++) begin
                wb_pipe[i] <= '0;
            end
        end else begin
            wb_pipe[0] <= {issue_valid, issue_row};
            for (int i = 1; i < PE_LAT; i++) begin
                wb_pipe[i] <= wb_pipe[i-1];
            end
        end
    end

    assign {wb_en, wb_row} = wb_pipe[PE_LAT-1];

endmodule

// File: tb/tb_gsim_sched.sv
// tb_gsim_sched: randomized self-checking bench for gsim_sched (N=16, NR_ITERATION=2, PE_LAT=3).
// Expected outputs come from a cycle-index schedule computed with plain arithmetic.
// Inputs are driven on the falling edge; outputs are sampled 1 time unit later.
module tb_gsim_sched;

    localparam int N  = 16;
    localparam int NR = 2;
    localparam int L  = 3;
    localparam int RW = 4;
    localparam int T  = N + L;          // cycles per iteration
    localparam int TOTAL = NR * T + N;  // cycles from first CALC to IDLE

    logic          clk = 1'b0;
    logic          reset;
    logic          in_en;
    logic          b_we;
    logic [RW-1:0] b_waddr;
    logic          issue_valid;
    logic [RW-1:0] issue_row;
    logic [5:0]    nbr_mask;
    logic          wb_en;
    logic [RW-1:0] wb_row;
    logic          out_valid;
    logic [RW-1:0] out_idx;
    logic          busy;
    logic          done;

    int n_pass  = 0;
    int n_total = 0;

    gsim_sched #(.N(N), .NR_ITERATION(NR), .PE_LAT(L)) dut (
        .clk        (clk),
        .reset      (reset),
        .in_en      (in_en),
        .b_we       (b_we),
        .b_waddr    (b_waddr),
        .issue_valid(issue_valid),
        .issue_row  (issue_row),
        .nbr_mask   (nbr_mask),
        .wb_en      (wb_en),
        .wb_row     (wb_row),
        .out_valid  (out_valid),
        .out_idx    (out_idx),
        .busy       (busy),
        .done       (done)
    );

    always #5 clk = ~clk;

    // Neighbour enable for row r: operand j refers to index r + offs[j].
    function automatic logic [5:0] ref_mask(input int r);
        int offs [6] = '{-1, 1, -2, 2, -3, 3};
        logic [5:0] m;
        m = '0;
        for (int j = 0; j < 6; j++) begin
            m[j] = (r + offs[j] >= 0) && (r + offs[j] < N);
        end
        return m;
    endfunction

    // Load N b values; mode 0 contiguous, 1 alternate cycles, 2 random gaps.
    task automatic do_load(input int mode);
        int cnt = 0;
        int cyc = 0;
        bit en;
        while (cnt < N && cyc < 200) begin
            @(negedge clk);
            case (mode)
                0:       en = 1'b1;
                1:       en = (cyc % 2 == 0);
                default: en = 1'($urandom_range(0, 1));
            endcase
            in_en = en;
            #1;
            n_total++;
            if (b_we !== en || (en && b_waddr !== RW'(cnt)))
                $display("FAIL load_write cyc=%0d got b_we=%0b b_waddr=%0d want b_we=%0b b_waddr=%0d",
                         cyc, b_we, b_waddr, en, cnt);
            else n_pass++;
            n_total++;
            if (busy !== (cnt > 0))
                $display("FAIL load_busy cyc=%0d got %0b want %0b", cyc, busy, (cnt > 0));
            else n_pass++;
            if (en) cnt++;
            cyc++;
        end
        n_total++;
        if (cnt != N) $display("FAIL load_count got %0d want %0d", cnt, N);
        else n_pass++;
    endtask

    // Full solve starting at the first CALC cycle. in_en mode: 0 low, 1 held high, 2 random.
    task automatic test_run(input int mode);
        int first_out = -1;
        bit en;
        logic          e_iv, e_wb, e_ov, e_done;
        logic [RW-1:0] e_row, e_wrow, e_oidx;
        logic [5:0]    e_mask;
        int p, kk, o;
        for (int k = 0; k <= TOTAL; k++) begin
            @(negedge clk);
            if (k == TOTAL)     en = 1'b0;
            else if (mode == 0) en = 1'b0;
            else if (mode == 1) en = 1'b1;
            else                en = 1'($urandom_range(0, 1));
            in_en = en;
            #1;
            p      = k % T;
            e_iv   = (k < NR * T) && (p < N);
            e_row  = e_iv ? RW'(p) : '0;
            e_mask = e_iv ? ref_mask(p) : '0;
            kk     = k - L;
            e_wb   = (kk >= 0) && (kk < NR * T) && (kk % T < N);
            e_wrow = e_wb ? RW'(kk % T) : '0;
            o      = k - NR * T;
            e_ov   = (o >= 0) && (o < N);
            e_oidx = e_ov ? RW'(o) : '0;
            e_done = e_ov && (o == N - 1);

            n_total++;
            if ({issue_valid, issue_row, nbr_mask} !== {e_iv, e_row, e_mask})
                $display("FAIL issue k=%0d got v=%0b row=%0d mask=%b want v=%0b row=%0d mask=%b",
                         k, issue_valid, issue_row, nbr_mask, e_iv, e_row, e_mask);
            else n_pass++;
            n_total++;
            if ({wb_en, wb_row} !== {e_wb, e_wrow})
                $display("FAIL writeback k=%0d got en=%0b row=%0d want en=%0b row=%0d",
                         k, wb_en, wb_row, e_wb, e_wrow);
            else n_pass++;
            n_total++;
            if ({out_valid, out_idx, done} !== {e_ov, e_oidx, e_done})
                $display("FAIL readout k=%0d got v=%0b idx=%0d done=%0b want v=%0b idx=%0d done=%0b",
                         k, out_valid, out_idx, done, e_ov, e_oidx, e_done);
            else n_pass++;
            n_total++;
            if (busy !== (k < TOTAL))
                $display("FAIL run_busy k=%0d got %0b want %0b", k, busy, (k < TOTAL));
            else n_pass++;
            n_total++;
            if (b_we !== 1'b0)
                $display("FAIL ignored_in_en k=%0d got b_we=%0b want 0", k, b_we);
            else n_pass++;
            if (out_valid === 1'b1 && first_out < 0) first_out = k;
        end
        n_total++;
        if (first_out != 38)
            $display("FAIL first_out_latency got %0d want 38", first_out);
        else n_pass++;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        in_en = 1'b0;
        repeat (3) @(negedge clk);
        #1;
        n_total++;
        if ({b_we, issue_valid, wb_en, out_valid, busy, done} !== 6'b0)
            $display("FAIL reset_held got %b want 000000",
                     {b_we, issue_valid, wb_en, out_valid, busy, done});
        else n_pass++;
        in_en = 1'b1;
        #1;
        n_total++;
        if (b_we !== 1'b1) $display("FAIL reset_bwe_follows got %0b want 1", b_we);
        else n_pass++;
        in_en = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        #1;
        n_total++;
        if ({b_we, b_waddr, issue_valid, issue_row, nbr_mask, wb_en, wb_row,
             out_valid, out_idx, busy, done} !== '0)
            $display("FAIL reset_outputs got we=%0b wa=%0d iv=%0b ir=%0d m=%b wb=%0b wr=%0d ov=%0b oi=%0d busy=%0b done=%0b want all 0",
                     b_we, b_waddr, issue_valid, issue_row, nbr_mask, wb_en, wb_row,
                     out_valid, out_idx, busy, done);
        else n_pass++;
    endtask

    task automatic test_contiguous();
        do_load(0);
        test_run(2);
    endtask

    task automatic test_gapped();
        do_load(1);
        test_run(1);
    endtask

    task automatic test_masks();
        int          rows [6]  = '{0, 1, 2, 8, 13, 15};
        logic [5:0]  masks [6] = '{6'b101010, 6'b101011, 6'b101111,
                                   6'b111111, 6'b011111, 6'b010101};
        do_load(2);
        for (int k = 0; k < N; k++) begin
            @(negedge clk);
            in_en = 1'b0;
            #1;
            for (int j = 0; j < 6; j++) begin
                if (rows[j] == k) begin
                    n_total++;
                    if (issue_valid !== 1'b1 || issue_row !== RW'(k) || nbr_mask !== masks[j])
                        $display("FAIL mask_row%0d got v=%0b row=%0d mask=%b want v=1 row=%0d mask=%b",
                                 k, issue_valid, issue_row, nbr_mask, k, masks[j]);
                    else n_pass++;
                end
            end
        end
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic test_reset_mid();
        do_load(0);
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            in_en = 1'b0;
        end
        @(negedge clk);
        #1;
        n_total++;
        if (issue_valid !== 1'b1 || issue_row !== RW'(7))
            $display("FAIL midreset_row got v=%0b row=%0d want v=1 row=7", issue_valid, issue_row);
        else n_pass++;
        reset = 1'b1;
        #1;
        n_total++;
        if (busy !== 1'b0 || issue_valid !== 1'b0)
            $display("FAIL midreset_async got busy=%0b iv=%0b want 0 0", busy, issue_valid);
        else n_pass++;
        @(negedge clk);
        reset = 1'b0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            #1;
            n_total++;
            if (wb_en !== 1'b0 || busy !== 1'b0 || issue_valid !== 1'b0)
                $display("FAIL midreset_quiet k=%0d got wb_en=%0b busy=%0b iv=%0b want 0 0 0",
                         k, wb_en, busy, issue_valid);
            else n_pass++;
        end
        do_load(2);
        test_run(0);
    endtask

    initial begin
        reset = 1'b1;
        in_en = 1'b0;
        test_reset();
        test_contiguous();
        test_gapped();
        test_masks();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
